spi_seq: RTL
============

Name: spi_seq

Overview:
- APB master that sequences one apb_spi peripheral, so multi-byte SPI transactions run without CPU polling.
- Accepts a transaction command (length, mode, divider, CS policy) and programs the apb_spi registers.
- Ping-pongs its A/B 32-bit buffers, polls the RUN bits, and streams RX words out.
- Sits between a DMA/boot-loader client and apb_spi's APB slave port.

Parameters:
- LEN_W, 16: width of the byte-count field cmd_len.
- POLL_MAX, 1023: maximum ctrl-register polls per run before an error is flagged.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command handshake, valid.
- cmd_ready  out  1  command handshake, ready; high only in IDLE.
- cmd_len  in  LEN_W  byte count minus 1 (0 means 1 byte).
- cmd_mode  in  2  SPI mode: bit1 = cpha, bit0 = cpol.
- cmd_div  in  8  value written to CLKDIV (0 = /2, n = /(2n+2)).
- cmd_keep_cs  in  1  1 = leave CS low after the transaction.
- tx_valid  in  1  TX word stream, valid.
- tx_ready  out  1  TX word stream, ready.
- tx_data  in  32  TX word; a partial final chunk is right-aligned, first byte in the MS valid byte.
- rx_valid  out  1  RX word stream, valid.
- rx_ready  in  1  RX word stream, ready.
- rx_data  out  32  RX word, same alignment as TX.
- rx_last  out  1  marks the final RX word.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky poll-timeout flag; cleared by the next accepted command.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PADDR  out  5  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.

Behaviour:
- apb_spi register map:
  - 0x00 CTRL: [0] cpol, [1] cpha, [7] RUN_A, [9:8] LEN_A, [10] RUN_B, [12:11] LEN_B; LEN fields hold bytes-1.
  - 0x04 TXA, 0x08 RXA, 0x0C CS ([0], 1 = deasserted), 0x10 CLKDIV, 0x14 TXB, 0x18 RXB.
- APB access (no wait states):
  - Setup cycle: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA valid.
  - Access cycle: PENABLE=1. Read data is captured on the clk edge that ends the access cycle.
  - One idle cycle (PSEL=0) follows every access. Each access therefore costs 3 cycles.
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=0 during reset then 1, tx_ready=rx_valid=rx_last=busy=err=0, FSM in IDLE.
- Chunking:
  - rem = cmd_len+1 bytes.
  - Chunk A = min(rem,4) bytes. If more bytes remain, chunk B = min(rem-4,4) bytes.
  - Both buffers launch with a single CTRL write.
- FSM states and transitions:
  - IDLE: cmd handshake latches len/mode/div/keep_cs and clears err -> CFG.
  - CFG: write CTRL = mode (RUN bits 0), write CLKDIV = div, write CS = 0 -> FETCH_A.
  - FETCH_A: tx_ready=1. On handshake, write TXA. If B is needed -> FETCH_B, else -> START.
  - FETCH_B: tx_ready=1. On handshake, write TXB -> START.
  - START: write CTRL = mode | RUN_A | LEN_A | (RUN_B | LEN_B if B needed) -> POLL.
  - POLL: read CTRL until [7]=0 and [10]=0 -> RD_A.
  - RD_A: read RXA, hold the word on rx_valid until rx_ready. If B was used -> RD_B, else -> NEXT.
  - RD_B: read RXB, hold on rx_valid until rx_ready -> NEXT.
  - NEXT: subtract the bytes sent from rem. If rem>0 -> FETCH_A. Else, if keep_cs=0, write CS = 1; then -> IDLE.
- Timeout: if the poll count exceeds POLL_MAX, set err, write CTRL = mode (clears RUN), write CS = 1, drop remaining data (no rx_valid) -> IDLE.
- rx_last=1 only on the final word of the transaction.
- TX stall: if tx_valid is low, the FSM waits in FETCH_x with the APB idle.
- RX backpressure: while rx_ready is low, no APB activity.
- rem arithmetic is LEN_W+1 bits wide with no wrap. cmd_len = 2^LEN_W-1 must work.
- Async reset mid-transaction: APB outputs go to 0 immediately. apb_spi state is not repaired; clients re-issue the command.

Decomposition:
- Shared package spi_seq_pkg: register offsets, CTRL bit positions, FSM state enum.
- One sub-module, apb_master_if: a small single-request APB engine.
  - Request side: req, addr, wdata, write.
  - Response side: done pulse, rdata.
  - The FSM issues one request at a time through it.

Test Plan:
- Bench: apb_spi with spi_dout looped back to spi_din throughout.
- 1 byte: cmd_len=0, mode 0, div 0, TX 0x000000A5 -> CTRL write 0x80; one rx word 0x000000A5 with rx_last=1; CS returns to 1.
- 8 bytes: cmd_len=7, mode 3, div 2, TX 0xCA7B17E5 then 0x0FEEDCA7 -> single CTRL write 0x1F83; rx words match in order, rx_last on the second.
- 11 bytes: cmd_len=10, mode 1 -> CTRL writes 0x1F82 then 0x0282; three rx words, the last right-aligned 3 bytes; rx_last on the third.
- Backpressure: hold rx_ready=0 for 50 cycles, and drop tx_valid for 20 cycles mid-stream -> no APB activity during the stalls; data is intact.
- Timeout: slave model holds CTRL[7]=1, POLL_MAX=4 -> err=1 after 5 polls; CS write 1; back to IDLE with busy=0.
- Reset: assert reset_n=0 during POLL -> PSEL=0 and busy=0 in the same cycle; a new command then completes normally.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the apb_spi sequencer: register map, CTRL fields, FSM encodings.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package spi_seq_pkg;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_TXA    = 5'h04;
  localparam logic [4:0] REG_RXA    = 5'h08;
  localparam logic [4:0] REG_CS     = 5'h0C;
  localparam logic [4:0] REG_CLKDIV = 5'h10;
  localparam logic [4:0] REG_TXB    = 5'h14;
  localparam logic [4:0] REG_RXB    = 5'h18;

  localparam int CTRL_RUN_A = 7;
  localparam int CTRL_LEN_A = 8;
  localparam int CTRL_RUN_B = 10;
  localparam int CTRL_LEN_B = 11;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_FETCH_A, S_FETCH_B, S_START,
    S_POLL, S_RD_A, S_RD_B, S_NEXT, S_ABORT
  } state_t;

  typedef enum logic [1:0] {
    A_IDLE, A_SETUP, A_ACCESS
  } apb_state_t;

  // Keeps the low nbytes bytes of a right-aligned word (1..4).
  function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    byte_mask = 32'h0000_00FF;
      3'd2:    byte_mask = 32'h0000_FFFF;
      3'd3:    byte_mask = 32'h00FF_FFFF;
      default: byte_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Single-request APB engine: setup, access, then one forced idle cycle (3 cycles per access).
// done pulses during the access cycle; req is ignored until the engine is idle again.
module apb_master_if
  import spi_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA
);

  apb_state_t st_q, st_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      A_IDLE:   if (req) st_d = A_SETUP;
      A_SETUP:  st_d = A_ACCESS;
      A_ACCESS: st_d = A_IDLE;
      default:  st_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= A_IDLE;
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == A_IDLE && req) begin
        PWRITE <= write;
        PADDR  <= addr;
        PWDATA <= wdata;
      end
    end
  end

  // Control strobes come straight from the state flop so reset clears them at once.
  assign PSEL    = (st_q != A_IDLE);
  assign PENABLE = (st_q == A_ACCESS);
  assign done    = (st_q == A_ACCESS);
  assign rdata   = PRDATA;

endmodule

// File: rtl/spi_seq.sv
// Sequences apb_spi over APB: config, A/B ping-pong TX load, launch, poll, RX stream-out.
// Stalls with APB idle while tx_valid is low or an RX word is held awaiting rx_ready.
module spi_seq
  import spi_seq_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int POLL_MAX = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_div,
  input  logic             cmd_keep_cs,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [31:0]      tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [31:0]      rx_data,
  output logic             rx_last,
  output logic             busy,
  output logic             err,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [4:0]       PADDR,
  output logic [31:0]      PWDATA,
  input  logic [31:0]      PRDATA
);

  localparam int PC_W = $clog2(POLL_MAX + 2);

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [LEN_W:0]   rem_q;
  logic [1:0]       mode_q;
  logic [7:0]       div_q;
  logic             keep_q;
  logic             err_q;
  logic [31:0]      tx_word_q;
  logic             tx_have_q;
  logic [31:0]      rx_word_q;
  logic             rx_pend_q;
  logic [PC_W-1:0]  poll_cnt_q;

  logic             req, req_write, done;
  logic [4:0]       req_addr;
  logic [31:0]      req_wdata, rdata;

  logic             rem_gt4, rem_gt8, poll_to;
  logic [2:0]       bytes_a, bytes_b;
  logic [3:0]       sent;
  logic [LEN_W:0]   rem_left;
  logic [31:0]      ctrl_base, ctrl_go;

  assign rem_gt4  = rem_q > (LEN_W+1)'(4);
  assign rem_gt8  = rem_q > (LEN_W+1)'(8);
  assign bytes_a  = rem_gt4 ? 3'd4 : rem_q[2:0];
  // rem is 5..8 whenever B is partial, so the 3-bit subtract wraps 8 onto 4 correctly.
  assign bytes_b  = rem_gt8 ? 3'd4 : (rem_q[2:0] - 3'd4);
  assign sent     = rem_gt4 ? (4'd4 + {1'b0, bytes_b}) : {1'b0, bytes_a};
  assign rem_left = rem_q - {{(LEN_W-3){1'b0}}, sent};
  assign poll_to  = (poll_cnt_q >= PC_W'(POLL_MAX));

  assign ctrl_base = {30'd0, mode_q};

  always_comb begin
    ctrl_go = ctrl_base;
    ctrl_go[CTRL_RUN_A] = 1'b1;
    ctrl_go[CTRL_LEN_A +: 2] = 2'(bytes_a - 3'd1);
    if (rem_gt4) begin
      ctrl_go[CTRL_RUN_B] = 1'b1;
      ctrl_go[CTRL_LEN_B +: 2] = 2'(bytes_b - 3'd1);
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && reset_n;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign rx_valid  = rx_pend_q;
  assign rx_data   = rx_word_q;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    req       = 1'b0;
    req_write = 1'b0;
    req_addr  = REG_CTRL;
    req_wdata = '0;
    tx_ready  = 1'b0;
    rx_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = S_CFG;
          step_d  = 2'd0;
        end
      end
      S_CFG: begin
        req       = 1'b1;
        req_write = 1'b1;
        case (step_q)
          2'd0:    req_wdata = ctrl_base;
          2'd1:    begin req_addr = REG_CLKDIV; req_wdata = {24'd0, div_q}; end
          default: req_addr = REG_CS;
        endcase
        if (done) begin
          step_d = step_q + 2'd1;
          if (step_q == 2'd2) state_d = S_FETCH_A;
        end
      end
      S_FETCH_A, S_FETCH_B: begin
        tx_ready  = !tx_have_q;
        req       = tx_have_q;
        req_write = 1'b1;
        req_addr  = (state_q == S_FETCH_A) ? REG_TXA : REG_TXB;
        req_wdata = tx_word_q;
        if (done) state_d = (state_q == S_FETCH_A && rem_gt4) ? S_FETCH_B : S_START;
      end
      S_START: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_wdata = ctrl_go;
        if (done) state_d = S_POLL;
      end
      S_POLL: begin
        req = 1'b1;
        if (done) begin
          if (!rdata[CTRL_RUN_A] && !rdata[CTRL_RUN_B]) state_d = S_RD_A;
          else if (poll_to) begin
            state_d = S_ABORT;
            step_d  = 2'd0;
          end
        end
      end
      S_RD_A: begin
        req      = !rx_pend_q;
        req_addr = REG_RXA;
        rx_last  = rx_pend_q && !rem_gt4;
        if (rx_pend_q && rx_ready) state_d = rem_gt4 ? S_RD_B : S_NEXT;
      end
      S_RD_B: begin
        req      = !rx_pend_q;
        req_addr = REG_RXB;
        rx_last  = rx_pend_q && !rem_gt8;
        if (rx_pend_q && rx_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (rem_left != '0) state_d = S_FETCH_A;
        else if (keep_q) state_d = S_IDLE;
        else begin
          req       = 1'b1;
          req_write = 1'b1;
          req_addr  = REG_CS;
          req_wdata = 32'd1;
          if (done) state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_addr  = (step_q == 2'd0) ? REG_CTRL : REG_CS;
        req_wdata = (step_q == 2'd0) ? ctrl_base : 32'd1;
        if (done) begin
          step_d = step_q + 2'd1;
          if (step_q != 2'd0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q      <= '0;
      mode_q     <= 2'd0;
      div_q      <= 8'd0;
      keep_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_word_q  <= '0;
      tx_have_q  <= 1'b0;
      rx_word_q  <= '0;
      rx_pend_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && cmd_valid && cmd_ready) begin
        rem_q  <= {1'b0, cmd_len} + (LEN_W+1)'(1);
        mode_q <= cmd_mode;
        div_q  <= cmd_div;
        keep_q <= cmd_keep_cs;
        err_q  <= 1'b0;
      end
      if (tx_valid && tx_ready) begin
        tx_word_q <= tx_data;
        tx_have_q <= 1'b1;
      end else if ((state_q == S_FETCH_A || state_q == S_FETCH_B) && done) begin
        tx_have_q <= 1'b0;
      end
      if (state_q == S_START && done) poll_cnt_q <= '0;
      if (state_q == S_POLL && done) begin
        poll_cnt_q <= poll_cnt_q + PC_W'(1);
        if ((rdata[CTRL_RUN_A] || rdata[CTRL_RUN_B]) && poll_to) err_q <= 1'b1;
      end
      if ((state_q == S_RD_A || state_q == S_RD_B) && done) begin
        rx_word_q <= rdata & byte_mask((state_q == S_RD_A) ? bytes_a : bytes_b);
        rx_pend_q <= 1'b1;
      end else if (rx_pend_q && rx_ready) begin
        rx_pend_q <= 1'b0;
      end
      if (state_q == S_NEXT && state_d != S_NEXT) rem_q <= rem_left;
    end
  end

  apb_master_if u_apb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .write   (req_write),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .done    (done),
    .rdata   (rdata),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA)
  );

endmodule
